// File: rtl/atm_seq_pkg.sv
// Shared definitions for the ATM frame sequencer.
package atm_seq_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CH_W   = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT,
        ST_WRITE,
        ST_GAP
    } atm_seq_state_t;

endpackage

// File: rtl/atm_frame_sequencer_next_ch.sv
// atm_next_ch: finds the next enabled channel in a mask.
// first=1: lowest set bit of mask; is_last when no other bit is set.
// first=0: lowest set bit above idx; is_last when nothing lies above idx.
module atm_next_ch
    import atm_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   idx,
    input  logic              first,
    output logic [CH_W-1:0]   next_idx,
    output logic              is_last
);

    logic found;
    logic more;

    // Priority scan from channel 0 upward; the first candidate wins.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        more     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask[i] && (first || (i > 32'(idx)))) begin
                if (!found) begin
                    next_idx = CH_W'(i);
                    found    = 1'b1;
                end else begin
                    more = 1'b1;
                end
            end
        end
        is_last = first ? !more : !found;
    end

endmodule

// File: rtl/atm_frame_sequencer.sv
// atm_frame_sequencer: scans enabled ATM channels, requests one ADC
// conversion per channel and writes each result as one frame FIFO word.
module atm_frame_sequencer
    import atm_seq_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [WORD_W-1:0] TIMEOUT_DATA   = 16'hFFFF
)(
    input  logic              sample_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [15:0]       frame_period,
    input  logic              clear_err,
    input  logic              adc_done,
    input  logic [WORD_W-1:0] adc_data,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_chsel,
    output logic              done,
    output logic [WORD_W-1:0] data_in,
    output logic [CH_W-1:0]   atmchsel,
    output logic              last_word,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    atm_seq_state_t state, next_state;

    logic [NUM_CH-1:0] mask_q,     mask_d;
    logic [CH_W-1:0]   ch_idx,     ch_idx_d;
    logic [15:0]       period_cnt, period_d;
    logic [15:0]       to_cnt,     to_d;
    logic [15:0]       period_inc;
    logic [15:0]       fcount_d;
    logic [WORD_W-1:0] data_d;
    logic [CH_W-1:0]   atmchsel_d;
    logic adc_start_d, done_d, last_d, busy_d, to_err_d, ovr_err_d;

    logic              scan_first;
    logic [NUM_CH-1:0] scan_mask;
    logic [CH_W-1:0]   scan_idx;
    logic              scan_last;
    logic can_start, period_reached, conv_end, frame_start;

    assign period_inc     = (period_cnt == '1) ? period_cnt : period_cnt + 16'd1;
    assign can_start      = enable && (ch_mask != '0);
    assign period_reached = (frame_period == '0) || (period_cnt >= frame_period - 16'd1);
    assign conv_end       = adc_done || (to_cnt == TO_LAST);

    // One scanner serves both roles: in IDLE/GAP it looks at the live mask
    // for a frame start, elsewhere it advances through the latched mask.
    assign scan_first = (state == ST_IDLE) || (state == ST_GAP);
    assign scan_mask  = scan_first ? ch_mask : mask_q;
    assign frame_start = scan_first && (next_state == ST_SELECT);

    // The mux channel is the current channel register, stable through WAIT.
    assign adc_chsel = ch_idx;

    atm_next_ch u_next_ch (
        .mask     (scan_mask),
        .idx      (ch_idx),
        .first    (scan_first),
        .next_idx (scan_idx),
        .is_last  (scan_last)
    );

    // State register.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (can_start) next_state = ST_SELECT;
            ST_SELECT: next_state = ST_WAIT;
            ST_WAIT:   if (conv_end) next_state = ST_WRITE;
            ST_WRITE:  next_state = scan_last ? ST_GAP : ST_SELECT;
            ST_GAP:    if (period_reached) next_state = can_start ? ST_SELECT : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Next values for the datapath and outputs; everything is registered so
    // each strobe is decided one state earlier than the cycle it appears in.
    always_comb begin
        mask_d      = mask_q;
        ch_idx_d    = ch_idx;
        period_d    = period_cnt;
        to_d        = to_cnt;
        adc_start_d = (next_state == ST_SELECT);
        done_d      = 1'b0;
        data_d      = data_in;
        atmchsel_d  = atmchsel;
        last_d      = 1'b0;
        busy_d      = (next_state != ST_IDLE);
        fcount_d    = frame_count;
        to_err_d    = timeout_err & ~clear_err;
        ovr_err_d   = overrun_err & ~clear_err;

        if (state != ST_IDLE) period_d = period_inc;

        case (state)
            ST_SELECT: to_d = '0;
            ST_WAIT: begin
                to_d = to_cnt + 16'd1;
                if (conv_end) begin
                    done_d     = 1'b1;
                    data_d     = adc_done ? adc_data : TIMEOUT_DATA;
                    atmchsel_d = ch_idx;
                    last_d     = scan_last;
                    if (!adc_done) to_err_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (scan_last) begin
                    fcount_d = frame_count + 16'd1;
                    if ((frame_period != '0) && (period_inc >= frame_period)) ovr_err_d = 1'b1;
                end else begin
                    ch_idx_d = scan_idx;
                end
            end
            default: ;
        endcase

        if (frame_start) begin
            mask_d   = ch_mask;
            ch_idx_d = scan_idx;
            period_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= '0;
            ch_idx      <= '0;
            period_cnt  <= '0;
            to_cnt      <= '0;
            adc_start   <= 1'b0;
            done        <= 1'b0;
            data_in     <= '0;
            atmchsel    <= '0;
            last_word   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            ch_idx      <= ch_idx_d;
            period_cnt  <= period_d;
            to_cnt      <= to_d;
            adc_start   <= adc_start_d;
            done        <= done_d;
            data_in     <= data_d;
            atmchsel    <= atmchsel_d;
            last_word   <= last_d;
            busy        <= busy_d;
            frame_count <= fcount_d;
            timeout_err <= to_err_d;
            overrun_err <= ovr_err_d;
        end
    end

endmodule

// File: doc/atm_frame_sequencer.md
# atm_frame_sequencer

Write-side controller for the frame FIFO in the `sample_clk` domain.
- Scans the enabled ATM channels in ascending order, one ADC conversion per channel.
- Turns each conversion result into one FIFO word write: `done`, `data_in`, `atmchsel`, plus `last_word` on the frame's final word.
- Paces frames at a programmable period and flags conversion timeouts and frame overruns.
- Sits between the ADC/mux front end and the dual-clock frame FIFO write port.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum `sample_clk` cycles spent in WAIT before a conversion is abandoned (1..65535).
- `TIMEOUT_DATA`, 16'hFFFF: word written in place of a timed-out conversion.
- `sample_clk` input 1: sole clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: run frames while high.
- `ch_mask` input 8: channel enable, bit n = ATM channel n.
- `frame_period` input 16: cycles from one frame start to the next. 0 = back-to-back frames.
- `clear_err` input 1: synchronous clear of the sticky error flags.
- `adc_done` input 1: one-cycle pulse, conversion complete.
- `adc_data` input 16: conversion result, valid while `adc_done` is high.
- `adc_start` output 1: one-cycle conversion request.
- `adc_chsel` output 3: mux channel; held stable from `adc_start` until leaving WAIT.
- `done` output 1: FIFO word write strobe, one cycle.
- `data_in` output 16: FIFO word data.
- `atmchsel` output 3: FIFO word slot, equal to the physical channel index.
- `last_word` output 1: high with `done` on the frame's final enabled channel.
- `busy` output 1: high in every state except IDLE.
- `frame_count` output 16: completed frames, wraps at 2^16.
- `timeout_err` output 1: sticky, a conversion timed out.
- `overrun_err` output 1: sticky, a frame took longer than `frame_period`.

## Operation
- States: IDLE, SELECT, WAIT, WRITE, GAP.
- IDLE → SELECT when `enable`=1 and `ch_mask`≠0.
  - Frame start: latch `ch_mask` into `mask_q`, set `ch_idx` to the lowest set bit, clear `period_cnt`.
- SELECT, 1 cycle: `adc_start`=1, `adc_chsel`=`ch_idx`; clear `to_cnt` → WAIT.
- WAIT: `to_cnt` increments each cycle.
  - `adc_done`=1 → capture `adc_data` → WRITE.
  - `to_cnt`=`TIMEOUT_CYCLES`-1 without `adc_done` → capture `TIMEOUT_DATA`, set `timeout_err` → WRITE.
  - `adc_done` on the same cycle as timeout: the done wins, no error.
- WRITE, 1 cycle: `done`=1, `data_in`=captured word, `atmchsel`=`ch_idx`.
  - `last_word`=1 iff `mask_q` has no set bit above `ch_idx`.
  - Not last: `ch_idx` ← next set bit of `mask_q` → SELECT.
  - Last: `frame_count`+1 → GAP.
- GAP:
  - `frame_period`=0 → behaves as reaching the period immediately.
  - `period_cnt` ≥ `frame_period`-1 → if `enable`=1 and `ch_mask`≠0, frame start → SELECT; otherwise IDLE.
  - On GAP entry, if `frame_period`≠0 and `period_cnt` ≥ `frame_period`, set `overrun_err`; the next frame then starts the following cycle.
- `period_cnt` increments every non-IDLE cycle and saturates at 16'hFFFF.
- Mid-frame changes:
  - `ch_mask` changes take effect at the next frame start only.
  - Dropping `enable` mid-frame completes the current frame (a frame always ends with `last_word`), then IDLE.
- `adc_done` outside WAIT is ignored.
- `clear_err`=1 clears both flags. A set event in the same cycle wins.
- Reset (any state, mid-frame included): state IDLE.
  - All outputs 0, `frame_count`=0, `mask_q`=0, counters 0.
  - A partially written frame is not completed.

## Timing
- All outputs are registered; no combinational path from input to output.
- `adc_start` is high in the cycle after the frame-start decision.
- `adc_done` sampled high at edge k → `done` high for the cycle after edge k; `data_in` holds the captured value until the next WRITE.
- Channel-to-channel overhead is 2 cycles (WRITE + SELECT) plus the conversion time.
- Minimum non-overrun `frame_period` is N·(conversion+2)+1 cycles for N enabled channels.
- `busy` falls in the cycle IDLE is entered.

## Structure
- Shared package `atm_seq_pkg`: `NUM_CH`=8, `WORD_W`=16, state enum `atm_seq_state_t`.
- Sub-module `atm_next_ch`: combinational, takes (`mask`, `idx`, `first`) and returns the next set bit and an `is_last` flag. It is used for both the frame start and the channel advance.

## Test plan
- `ch_mask`=8'b1010_0101, `frame_period`=0, ADC replies 3 cycles after each `adc_start` with data 16'h1000+ch.
  - Expect `done` with `atmchsel`=0,2,5,7, `last_word` only at 7.
  - Expect `frame_count` to increment once per frame.
- `ch_mask`=8'h01, `frame_period`=100: frame starts every 100 cycles exactly; `overrun_err`=0.
- `ch_mask`=8'hFF, `frame_period`=10: `overrun_err` sets; next frame starts the cycle after GAP entry; `clear_err` clears it.
- `adc_done` never arrives, `TIMEOUT_CYCLES`=16: `done` with `data_in`=16'hFFFF; `timeout_err`=1; sequence continues to the next channel.
- Mid-frame changes:
  - Drop `enable` after the 2nd of 4 words: remaining 2 words still written with `last_word`, then `busy`=0.
  - Change `ch_mask` mid-frame: the current frame keeps the old mask.
- Assert `reset_n`=0 in WAIT: all outputs 0 immediately; after release, with `enable`=1, the first `adc_start` selects the lowest channel.
